// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes ALUOp/funct into ALU slice controls and presents
// operands plus controls through a 2-entry registered skid buffer.
module alu_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             Ainvert,
    output logic             Binvert,
    output logic             Carry_in,
    output logic [1:0]       Operation,
    output logic             illegal,
    output logic [15:0]      issue_count
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ill;
        logic [4:0]       ctl;
    } entry_t;

    state_t      state_q, state_d;
    entry_t      main_q, main_d, skid_q, skid_d, dec;
    logic [5:0]  dec_ctl;
    logic [15:0] cnt_q, cnt_d;
    logic        in_fire, out_fire;

    // dec_ctl = {illegal, Ainvert, Binvert, Carry_in, Operation}
    always_comb begin
        dec_ctl = 6'b100000;
        case (alu_op)
            2'b00: dec_ctl = 6'b000010;
            2'b01: dec_ctl = 6'b001110;
            2'b10: begin
                case (funct)
                    6'b100000: dec_ctl = 6'b000010;
                    6'b100010: dec_ctl = 6'b001110;
                    6'b100100: dec_ctl = 6'b000000;
                    6'b100101: dec_ctl = 6'b000001;
                    6'b100111: dec_ctl = 6'b011000;
                    6'b101010: dec_ctl = 6'b001111;
                    default:   dec_ctl = 6'b100000;
                endcase
            end
            default: dec_ctl = 6'b100000;
        endcase
    end

    assign dec       = {in_a, in_b, dec_ctl};
    assign out_valid = state_q != EMPTY;
    assign in_ready  = state_q != FULL;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign {a_out, b_out, illegal, Ainvert, Binvert, Carry_in, Operation} = main_q;
    assign issue_count = cnt_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = dec;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = dec;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end else if (in_fire) begin
                    skid_d  = dec;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
        cnt_d = (out_fire && !flush && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
